// File: rtl/time_bcd_to_count_pkg.sv
// Shared constants and types for the BCD time-entry path and the timekeeping formatter.
// The nibble positions and time-base constants are kept here so both directions of the conversion agree.
package time_bcd_to_count_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HOURS = 3'd2,
        ST_MIN   = 3'd3,
        ST_SEC   = 3'd4,
        ST_FRAC  = 3'd5,
        ST_DONE  = 3'd6
    } conv_state_t;

    localparam int H1_MSB = 31;
    localparam int H1_LSB = 28;
    localparam int H2_MSB = 27;
    localparam int H2_LSB = 24;
    localparam int M1_MSB = 23;
    localparam int M1_LSB = 20;
    localparam int M2_MSB = 19;
    localparam int M2_LSB = 16;
    localparam int S1_MSB = 15;
    localparam int S1_LSB = 12;
    localparam int S2_MSB = 11;
    localparam int S2_LSB = 8;
    localparam int F1_MSB = 7;
    localparam int F1_LSB = 4;
    localparam int F2_MSB = 3;
    localparam int F2_LSB = 0;

    localparam int MAX_COUNT          = 8640000;
    localparam int HOURS_PER_HALF_DAY = 12;
    localparam int SEC_PER_MIN        = 60;
    localparam int HUND_PER_SEC       = 100;

    // Two BCD digits to binary; 10*t is built as (t<<3)+(t<<1).
    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/time_bcd_to_count_digit_check.sv
// Combinational validation of a packed 12-hour BCD time and split into binary two-digit fields.
module time_digit_check
    import time_bcd_to_count_pkg::*;
(
    input  logic [31:0] bcd_i,
    output logic        valid_o,
    output logic [6:0]  hour_o,
    output logic [6:0]  min_o,
    output logic [6:0]  sec_o,
    output logic [6:0]  frac_o
);

    logic nibbles_ok;

    assign hour_o = bcd2bin(bcd_i[H1_MSB:H1_LSB], bcd_i[H2_MSB:H2_LSB]);
    assign min_o  = bcd2bin(bcd_i[M1_MSB:M1_LSB], bcd_i[M2_MSB:M2_LSB]);
    assign sec_o  = bcd2bin(bcd_i[S1_MSB:S1_LSB], bcd_i[S2_MSB:S2_LSB]);
    assign frac_o = bcd2bin(bcd_i[F1_MSB:F1_LSB], bcd_i[F2_MSB:F2_LSB]);

    always_comb begin
        nibbles_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bcd_i[i*4 +: 4] > 4'd9) nibbles_ok = 1'b0;
        end
    end

    // Field range checks are only meaningful once every nibble is a decimal digit.
    assign valid_o = nibbles_ok
                   && (bcd_i[H1_MSB:H1_LSB] <= 4'd1)
                   && (hour_o >= 7'd1)
                   && (hour_o <= 7'(HOURS_PER_HALF_DAY))
                   && (bcd_i[M1_MSB:M1_LSB] <= 4'd5)
                   && (bcd_i[S1_MSB:S1_LSB] <= 4'd5);

endmodule

// File: rtl/time_bcd_to_count.sv
// Converts a user-entered 12-hour BCD time plus AM/PM into a linear hundredths-of-second count.
// Handshake: i_Start is taken only in IDLE; o_Done pulses once per accepted request, with o_Error qualifying it.
module time_bcd_to_count
    import time_bcd_to_count_pkg::*;
#(
    parameter int BIT_WIDTH = 24,
    parameter int MAX_COUNT = time_bcd_to_count_pkg::MAX_COUNT
) (
    input  logic                 i_Clk_5MHz,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic [31:0]          i_Time,
    input  logic                 i_PM,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Error,
    output logic [BIT_WIDTH-1:0] o_Count
);

    if (BIT_WIDTH < $clog2(MAX_COUNT)) begin : g_width_check
        $error("BIT_WIDTH too small to hold MAX_COUNT-1");
    end

    conv_state_t          state_q, state_d;
    logic [31:0]          time_q, time_d;
    logic                 pm_q, pm_d;
    logic [BIT_WIDTH-1:0] acc_q, acc_d;
    logic [BIT_WIDTH-1:0] count_q, count_d;
    logic                 error_q, error_d;
    logic                 busy_q, done_q;

    logic       fields_valid;
    logic [6:0] hour_bin, min_bin, sec_bin, frac_bin;
    logic [6:0] hour24;

    time_digit_check u_check (
        .bcd_i   (time_q),
        .valid_o (fields_valid),
        .hour_o  (hour_bin),
        .min_o   (min_bin),
        .sec_o   (sec_bin),
        .frac_o  (frac_bin)
    );

    // 12 AM is hour 0 of the day; 12 PM stays 12; other PM hours shift by 12.
    always_comb begin
        hour24 = (hour_bin == 7'(HOURS_PER_HALF_DAY)) ? 7'd0 : hour_bin;
        if (pm_q) hour24 = hour24 + 7'(HOURS_PER_HALF_DAY);
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pm_d    = pm_q;
        acc_d   = acc_q;
        count_d = count_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    time_d  = i_Time;
                    pm_d    = i_PM;
                    error_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (fields_valid) begin
                    state_d = ST_HOURS;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_HOURS: begin
                acc_d   = BIT_WIDTH'(hour24);
                state_d = ST_MIN;
            end
            ST_MIN: begin
                acc_d   = (acc_q << 6) - (acc_q << 2) + BIT_WIDTH'(min_bin);
                state_d = ST_SEC;
            end
            ST_SEC: begin
                acc_d   = (acc_q << 6) - (acc_q << 2) + BIT_WIDTH'(sec_bin);
                state_d = ST_FRAC;
            end
            ST_FRAC: begin
                acc_d   = (acc_q << 6) + (acc_q << 5) + (acc_q << 2) + BIT_WIDTH'(frac_bin);
                count_d = acc_d;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            pm_q    <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pm_q    <= pm_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            error_q <= error_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign o_Busy  = busy_q;
    assign o_Done  = done_q;
    assign o_Error = error_q;
    assign o_Count = count_q;

endmodule

// File: tb/tb_time_bcd_to_count.sv
// Directed and round-trip bench for the BCD time to hundredths-count converter.
module tb_time_bcd_to_count;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Start = 1'b0;
    logic [31:0] i_Time = '0;
    logic        i_PM = 1'b0;
    logic        o_Busy, o_Done, o_Error;
    logic [23:0] o_Count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    time_bcd_to_count #(.BIT_WIDTH(24), .MAX_COUNT(8640000)) dut (
        .i_Clk_5MHz (clk),
        .i_Reset    (i_Reset),
        .i_Start    (i_Start),
        .i_Time     (i_Time),
        .i_PM       (i_PM),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done),
        .o_Error    (o_Error),
        .o_Count    (o_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Drives one request; the following posedge is cycle 0 of the conversion.
    task automatic start_conv(input logic [31:0] t, input logic pm);
        @(negedge clk);
        i_Time  = t;
        i_PM    = pm;
        i_Start = 1'b1;
        @(posedge clk);
        #1 i_Start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        while (cyc < 20) begin
            step();
            if (o_Done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check("done_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic convert(input string tag, input logic [31:0] t, input logic pm,
                           input int exp_cyc, input logic exp_err, input logic [31:0] exp_cnt);
        int dc;
        start_conv(t, pm);
        wait_done(dc);
        check({tag, "_cycle"}, 32'(dc), 32'(exp_cyc));
        check({tag, "_err"}, 32'(o_Error), 32'(exp_err));
        check({tag, "_count"}, 32'(o_Count), exp_cnt);
        step();
        check({tag, "_pulse"}, 32'(o_Done), 32'd0);
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Independent formatter model: linear count to 12-hour BCD plus PM flag.
    function automatic logic [32:0] count_to_time(input int c);
        int f, s, m, h24, h12;
        f   = c % 100;
        s   = (c / 100) % 60;
        m   = (c / 6000) % 60;
        h24 = c / 360000;
        h12 = h24 % 12;
        if (h12 == 0) h12 = 12;
        return {(h24 >= 12), to_bcd2(h12), to_bcd2(m), to_bcd2(s), to_bcd2(f)};
    endfunction

    initial begin
        int dc;
        int seen_done;
        logic [31:0] bad_vec[4];
        logic [32:0] tp;
        logic [31:0] want;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        check("rst_err", 32'(o_Error), 32'd0);
        check("rst_count", 32'(o_Count), 32'd0);
        i_Reset = 1'b0;

        // Midnight, also verifying busy rises right after acceptance.
        start_conv(32'h1200_0000, 1'b0);
        step();
        check("midnight_busy", 32'(o_Busy), 32'd1);
        wait_done(dc);
        check("midnight_cycle", 32'(dc), 32'd6);
        check("midnight_err", 32'(o_Error), 32'd0);
        check("midnight_count", 32'(o_Count), 32'd0);

        convert("max", 32'h1159_5999, 1'b1, 6, 1'b0, 32'd8639999);
        convert("noon", 32'h1230_1550, 1'b1, 6, 1'b0, 32'd4501550);
        convert("am7", 32'h0730_1550, 1'b0, 6, 1'b0, 32'd2701550);

        bad_vec[0] = 32'h1300_0000;
        bad_vec[1] = 32'h0000_0000;
        bad_vec[2] = 32'h0760_0000;
        bad_vec[3] = 32'h010A_0000;
        for (int i = 0; i < 4; i++) begin
            convert($sformatf("preload%0d", i), 32'h1230_1550, 1'b1, 6, 1'b0, 32'd4501550);
            convert($sformatf("bad%0d", i), bad_vec[i], 1'b0, 2, 1'b1, 32'd4501550);
            check($sformatf("bad%0d_err_held", i), 32'(o_Error), 32'd1);
        end
        start_conv(32'h0730_1550, 1'b0);
        step();
        check("err_clear_on_accept", 32'(o_Error), 32'd0);
        wait_done(dc);
        check("err_clear_count", 32'(o_Count), 32'd2701550);

        // Re-start during conversion with different inputs must be ignored.
        start_conv(32'h1159_5999, 1'b1);
        step(); step(); step();
        i_Time  = 32'h1200_0000;
        i_PM    = 1'b0;
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        wait_done(dc);
        check("ign_cycle", 32'(dc), 32'd6);
        check("ign_count", 32'(o_Count), 32'd8639999);

        // Start held through the DONE cycle: ignored there, accepted in the next IDLE cycle.
        i_Time  = 32'h0730_1550;
        i_PM    = 1'b0;
        i_Start = 1'b1;
        @(negedge clk);
        check("done_start_ignored_busy", 32'(o_Busy), 32'd0);
        @(posedge clk);
        #1 i_Start = 1'b0;
        cyc = 0;
        wait_done(dc);
        check("back2back_cycle", 32'(dc), 32'd6);
        check("back2back_count", 32'(o_Count), 32'd2701550);

        // Reset in the middle of a conversion.
        start_conv(32'h1230_1550, 1'b1);
        step(); step(); step(); step();
        i_Reset = 1'b1;
        step();
        check("midrst_busy", 32'(o_Busy), 32'd0);
        check("midrst_done", 32'(o_Done), 32'd0);
        check("midrst_count", 32'(o_Count), 32'd0);
        i_Reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_Done === 1'b1) seen_done++;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);

        // Round trip through the formatter model.
        for (int i = 0; i < 1000; i++) begin
            want = 32'($urandom_range(0, 8639999));
            tp = count_to_time(int'(want));
            exp_q.push_back(want);
            start_conv(tp[31:0], tp[32]);
            wait_done(dc);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check($sformatf("rt%0d_count", i), 32'(o_Count), want);
                if (o_Error !== 1'b0) check($sformatf("rt%0d_err", i), 32'(o_Error), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
